// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// word packing constants and the halt opcode used by program images.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 32;
  localparam logic [5:0] HALT_OPCODE = 6'b010011;

  // A load request is only meaningful for 1..depth words.
  function automatic logic count_ok(input int cnt, input int depth);
    return (cnt >= 1) && (cnt <= depth);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_full flags the
// cycle in which the final byte of a word is being shifted in.
module byte_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      word_q;

  // Counter wraps to zero after the last byte, ready for the next word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (shift_en) begin
      cnt_q  <= cnt_q + 1'b1;
      word_q <= {word_q[23:0], byte_in};
    end
  end

  assign word      = word_q;
  assign word_full = shift_en && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot sequencer: loads a byte-streamed program into instruction memory,
// then runs the processor and supervises it for halt and PC range faults.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              restart,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic [31:0]       mem_rd_addr,
  input  logic [31:0]       cpu_pc,
  input  logic              cpu_halt,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic              pc_fault,
  output logic [2:0]        state
);

  localparam logic [31:0]   PC_LIMIT = 32'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   widx_q;
  logic              pc_fault_q;

  logic              load_ok;
  logic              accept_load;
  logic              set_fault;
  logic              byte_xfer;
  logic [31:0]       asm_word;
  logic              asm_full;

  assign load_ok   = load_start && count_ok(int'(word_count), DEPTH);
  assign byte_xfer = rx_valid && rx_ready;

  byte_word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (accept_load),
    .shift_en  (byte_xfer),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      widx_q     <= '0;
      pc_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_load) begin
        count_q    <= word_count;
        widx_q     <= '0;
        pc_fault_q <= 1'b0;
      end else if (state_q == ST_WRITE) begin
        widx_q <= widx_q + IDX_ONE;
      end
      if (set_fault) begin
        pc_fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_ready    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;
    cpu_run     = 1'b0;
    load_done   = 1'b0;
    load_err    = 1'b0;
    accept_load = 1'b0;
    set_fault   = 1'b0;

    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (load_start) begin
          if (load_ok) begin
            accept_load = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            load_err = 1'b1;
          end
        end
      end

      // load_start has priority over restart, even when it is rejected.
      ST_HALTED: begin
        if (load_start) begin
          if (load_ok) begin
            accept_load = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            load_err = 1'b1;
          end
        end else if (restart) begin
          state_d = ST_RUN;
        end
      end

      ST_LOAD: begin
        rx_ready = 1'b1;
        if (asm_full) begin
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = widx_q[ADDR_W-1:0];
        mem_wr_data = asm_word;
        if ((widx_q + IDX_ONE) == count_q) begin
          load_done = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end

      // A PC fault outranks a simultaneous halt.
      ST_RUN: begin
        cpu_run     = 1'b1;
        mem_rd_addr = cpu_pc;
        if (cpu_pc >= PC_LIMIT) begin
          set_fault = 1'b1;
          state_d   = ST_FAULT;
        end else if (cpu_halt) begin
          state_d = ST_HALTED;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc_fault = pc_fault_q;
  assign state    = state_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot/load sequencer for the instruction memory. Receives a program as a byte stream over a valid/ready link and packs it into 32-bit words, MSB byte first. Writes the words into consecutive instruction-memory addresses, then releases the processor to fetch. Owns the instruction-memory address mux: the loader holds it during load, cpu_pc drives it during run. Also supervises the run for halt and out-of-range PC.

Parameters:
DEPTH, 32, number of instruction words in instruction memory
ADDR_W, 5, write-address width (log2 DEPTH)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
load_start  in  1  one-cycle request to begin a program load
word_count  in  ADDR_W+1  number of words to load, valid 1..DEPTH, sampled with load_start
restart  in  1  resume execution from HALTED without reload
rx_data  in  8  program byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts a byte this cycle
mem_wr_en  out  1  instruction-memory write strobe
mem_wr_addr  out  ADDR_W  write word address
mem_wr_data  out  32  write word
mem_rd_addr  out  32  instruction-memory read address
cpu_pc  in  32  processor PC
cpu_halt  in  1  processor executed halt
cpu_run  out  1  processor enabled; low holds the processor
load_done  out  1  one-cycle pulse on the final word write
load_err  out  1  one-cycle pulse on a rejected load_start
pc_fault  out  1  sticky; set on PC out of range, cleared by the next accepted load
state  out  3  current state encoding, for debug

Behaviour:
- Reset state: state=IDLE. All outputs 0, including mem_rd_addr and pc_fault. Byte/word counters and the assembly register are 0.
- States: IDLE, LOAD, WRITE, RUN, HALTED, FAULT.
- IDLE/HALTED/FAULT, load_start=1:
  - word_count in 1..DEPTH: latch count, clear counters, clear pc_fault, go to LOAD.
  - Otherwise: load_err=1 for one cycle, state unchanged.
- LOAD: rx_ready=1.
  - A byte transfers on rx_valid&rx_ready and is shifted into the assembly register: word = {word[23:0], rx_data}.
  - On the 4th byte, go to WRITE.
  - load_start is ignored.
- WRITE (exactly 1 cycle): rx_ready=0, mem_wr_en=1, mem_wr_addr=word index, mem_wr_data=assembled word.
  - Word index increments after the write.
  - If this is the last word: load_done=1 this cycle, next state RUN. Otherwise return to LOAD.
  - Latency: write occurs 1 cycle after the 4th byte handshake.
- RUN: cpu_run=1, mem_rd_addr=cpu_pc.
  - cpu_pc >= DEPTH: set pc_fault, go to FAULT.
  - Else cpu_halt=1: go to HALTED.
  - If both occur in the same cycle, the fault wins.
  - load_start and restart are ignored.
- All states except RUN: cpu_run=0, mem_rd_addr=0.
- HALTED: restart=1 goes to RUN with no reload. load_start=1 reloads. If both occur in the same cycle, load_start wins.
- FAULT: restart is ignored; only load_start leaves this state.
- Reset mid-load: the partial word is discarded and no write is issued. Words already written stay in memory.
- Words above word_count are not touched.
- cpu_run changes only on state transitions, so there are no single-cycle glitches.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, LOAD=1, WRITE=2, RUN=3, HALTED=4, FAULT=5
  - BYTES_PER_WORD=4
  - DEPTH default
  - the 6-bit halt opcode 010011, for the bench
- Sub-module byte_word_assembler: 2-bit byte counter plus 32-bit shift register, with a word_full output. The FSM, address counter and read mux stay in instr_mem_loader.

Test Plan:
- Load word_count=2 with bytes 48 00 00 00 30 01 00 01 and rx_valid held high → writes addr0=0x48000000 and addr1=0x30010001. load_done is asserted with the second write. cpu_run=1 the next cycle.
- word_count=0, then word_count=33 → load_err pulses each time, state stays IDLE, no writes.
- Stall test: rx_valid toggled 1/0 every cycle, 1 word 0x4C000000 → exactly one write after the 4th accepted byte. rx_ready is 0 in the WRITE cycle.
- In RUN, drive cpu_pc=5 → mem_rd_addr=5. Assert cpu_halt → HALTED, cpu_run=0. Pulse restart → RUN again.
- In RUN, drive cpu_pc=32 with cpu_halt=1 in the same cycle → FAULT and pc_fault=1. restart has no effect. A new valid load clears pc_fault.
- Reset low after 2 of 4 bytes → no mem_wr_en, state=IDLE, all outputs 0. Reloading afterwards writes the correct word at addr0.
